// File: rtl/rle_sequencer.sv
// rle_sequencer: run-length encoder turning a ready/valid sample stream into (value, length) tokens.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : sample handshake; in_data is the DATA_W-bit sample
//   flush                 : close the open run (only when RLE_FLUSH_EN is defined)
//   out_valid/out_ready   : token handshake from the registered output slot
//   out_data/out_len      : run value and run length (1..2^CNT_W-1)
//   busy                  : a run is currently open
// Optional feature macro: RLE_FLUSH_EN adds the flush port.
module rle_sequencer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef RLE_FLUSH_EN
  input  logic              flush,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_len,
  output logic              busy
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] cur_val_q, cur_val_d, out_data_q, out_data_d;
  logic [CNT_W-1:0]  cur_len_q, cur_len_d, out_len_q, out_len_d;
  logic              out_valid_q, out_valid_d;
  logic              slot_free, flush_active, accept, emit;
`ifdef RLE_FLUSH_EN
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = slot_free && !flush_active && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
  assign busy      = (state_q == RUN);
  always_comb begin
    state_d     = state_q;
    cur_val_d   = cur_val_q;
    cur_len_d   = cur_len_q;
    emit        = 1'b0;
    if (accept) begin
      if (state_q == IDLE) begin
        state_d   = RUN;
        cur_val_d = in_data;
        cur_len_d = CNT_W'(1);
      end else if (in_data == cur_val_q) begin
        // a full counter closes the run and restarts it with the same value
        emit      = (cur_len_q == MAX);
        cur_len_d = (cur_len_q == MAX) ? CNT_W'(1) : cur_len_q + CNT_W'(1);
      end else begin
        emit      = 1'b1;
        cur_val_d = in_data;
        cur_len_d = CNT_W'(1);
      end
    end else if (flush_active && state_q == RUN && slot_free) begin
      emit      = 1'b1;
      state_d   = IDLE;
      cur_len_d = '0;
    end
    // emit always lands in a free slot, so a coinciding drain is simply overwritten
    out_valid_d = emit ? 1'b1 : (out_valid_q && !out_ready);
    out_data_d  = emit ? cur_val_q : out_data_q;
    out_len_d   = emit ? cur_len_q : out_len_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_val_q   <= '0;
      cur_len_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_val_q   <= cur_val_d;
      cur_len_q   <= cur_len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
    end
  end
endmodule

// File: tb/tb_rle_sequencer.sv
// tb_rle_sequencer: directed scoreboard bench for rle_sequencer (CNT_W=8 main unit, CNT_W=2 saturation unit).
module tb_rle_sequencer;
  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy, flush;
  logic [7:0] in_data, out_data, out_len;
  logic       s_in_valid, s_in_ready, s_out_valid, s_busy;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_out_len;
  logic [15:0] q[$], sq[$];
  int n_assert = 0, n_fail = 0;

  rle_sequencer #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef RLE_FLUSH_EN
    .flush(flush),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len), .busy(busy));

  rle_sequencer #(.DATA_W(8), .CNT_W(2)) sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
`ifdef RLE_FLUSH_EN
    .flush(1'b0),
`endif
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_len(s_out_len), .busy(s_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    in_data = d;
    in_valid = 1'b1;
    #1 chk("send_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic s_send(input logic [7:0] d);
    s_in_data = d;
    s_in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every token taken by the consumer must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_pending", 32'(q.size() != 0), 1);
      if (q.size() != 0) chk("sb_token", {16'h0, out_data, out_len}, {16'h0, q.pop_front()});
    end
    if (rst_n && s_out_valid && out_ready) begin
      chk("sat_pending", 32'(sq.size() != 0), 1);
      if (sq.size() != 0) chk("sat_token", {16'h0, s_out_data, 6'h0, s_out_len}, {16'h0, sq.pop_front()});
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_len", 32'(out_len), 0);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    // saturation split on the CNT_W=2 unit
    sq.push_back({8'h55, 8'd3});
    sq.push_back({8'h55, 8'd3});
    sq.push_back({8'h55, 8'd1});
    for (int i = 0; i < 7; i++) begin
      s_send(8'h55);
      if (i == 3) begin
        chk("sat_split_valid", 32'(s_out_valid), 1);
        chk("sat_split_len", 32'(s_out_len), 3);
      end
    end
    s_send(8'h66);
    s_in_valid = 1'b0;
    chk("sat_last_len", 32'(s_out_len), 1);
    repeat (2) @(posedge clk);
    #1;
    // basic runs
    send(8'h11); send(8'h11); send(8'h11);
    chk("run_no_token", 32'(out_valid), 0);
    chk("run_busy", 32'(busy), 1);
    q.push_back({8'h11, 8'd3});
    send(8'h22);
    chk("tok1_valid", 32'(out_valid), 1);
    chk("tok1", {out_data, out_len}, {8'h11, 8'd3});
    q.push_back({8'h22, 8'd1});
    send(8'h33);
    chk("tok2", {out_data, out_len}, {8'h22, 8'd1});
    send(8'h33);
    chk("open_no_token", 32'(out_valid), 0);
    chk("open_busy", 32'(busy), 1);
    // backpressure
    q.push_back({8'h33, 8'd2});
    send(8'h0A); send(8'h0A);
    out_ready = 1'b0;
    q.push_back({8'h0A, 8'd2});
    send(8'h0B);
    in_data = 8'h0C;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_token", {out_valid, out_data, out_len}, {1'b1, 8'h0A, 8'd2});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 1);
    q.push_back({8'h0B, 8'd1});
    @(posedge clk);
    #1 chk("bp_b2b", {out_valid, out_data, out_len}, {1'b1, 8'h0B, 8'd1});
    // alternating samples: every sample closes a length-1 run
    for (int i = 0; i < 10; i++) begin
      q.push_back({(i == 0) ? 8'h0C : ((i % 2) ? 8'h01 : 8'h02), 8'd1});
      send((i % 2) ? 8'h02 : 8'h01);
      chk("alt_valid", 32'(out_valid), 1);
    end
`ifdef RLE_FLUSH_EN
    out_ready = 1'b0;
    in_valid = 1'b0;
    flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("fl_wait", {out_data, out_len, 6'h0, busy}, {8'h01, 8'd1, 7'h1});
    end
    out_ready = 1'b1;
    q.push_back({8'h02, 8'd1});
    @(posedge clk);
    #1 chk("fl_emit", {out_valid, out_data, out_len, busy}, {1'b1, 8'h02, 8'd1, 1'b0});
    flush = 1'b0;
    send(8'h7F); send(8'h7F); send(8'h7F); send(8'h7F);
    in_valid = 1'b0;
    chk("fl_run_open", {out_valid, busy}, 2'b01);
    out_ready = 1'b0;
    flush = 1'b1;
    q.push_back({8'h7F, 8'd4});
    @(posedge clk);
    #1 chk("fl_7f", {out_valid, out_data, out_len, busy}, {1'b1, 8'h7F, 8'd4, 1'b0});
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("fl_idle_noop", 32'(out_valid), 0);
    flush = 1'b0;
`else
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    q.push_back({8'h02, 8'd1});
`endif
    // reset mid-run with a pending token
    send(8'h44); send(8'h44);
    out_ready = 1'b0;
    send(8'h45);
    in_valid = 1'b0;
    chk("pre_rst_pending", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_len", 32'(out_len), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_state", {in_ready, busy, out_valid}, 3'b100);
    out_ready = 1'b1;
    q.push_back({8'h55, 8'd1});
    send(8'h55); send(8'h56);
    in_valid = 1'b0;
    chk("after_rst_tok", {out_valid, out_data, out_len}, {1'b1, 8'h55, 8'd1});
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 0);
    chk("sat_drained", 32'(sq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
